onset_detector: RTL and testbench
=================================

ONSET_DETECTOR -- requirements
Module: onset_detector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample and threshold bit width.
REQ-002 SHALL have parameter TS_WIDTH, default 32, timestamp counter width.
REQ-003 SHALL have parameter CONFIRM_SAMPLES, default 4, range 1..255, consecutive above-threshold samples needed to declare an onset.
REQ-004 SHALL have parameter HOLDOFF_SAMPLES, default 1024, range 1..65535, minimum valid samples between onsets.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port sresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port sample_in, input, DATA_WIDTH, unsigned smoothed envelope sample from the upstream averaging window.
REQ-008 SHALL have port sample_valid, input, 1, sample_in qualifier; no backpressure.
REQ-009 SHALL have port threshold_hi, input, DATA_WIDTH, arm level, quasi-static.
REQ-010 SHALL have port threshold_lo, input, DATA_WIDTH, re-arm level, quasi-static; threshold_lo <= threshold_hi is required.
REQ-011 SHALL have port enable, input, 1, detector enable.
REQ-012 SHALL have port onset_valid, output, 1, single-cycle onset pulse.
REQ-013 SHALL have port onset_timestamp, output, TS_WIDTH, clk-cycle timestamp of the first above-threshold sample of the onset.
REQ-014 SHALL have port busy, output, 1, high in CONFIRM or HOLDOFF.
REQ-015 SHALL have port onset_peak, output, DATA_WIDTH, present only when ONSET_PEAK_EN is defined.

Function
REQ-016 SHALL run a free-running TS_WIDTH timestamp counter that increments every clk, wraps from all-ones to 0, and ignores enable.
REQ-017 SHALL make all comparisons unsigned; "above" means sample_in > threshold_hi; "below" means sample_in < threshold_lo.
REQ-018 SHALL implement states IDLE, CONFIRM and HOLDOFF, and act on sample_in only in cycles with sample_valid=1.
REQ-019 IDLE: on a valid above sample with enable=1, SHALL latch the current timestamp into a candidate register, set confirm count to 1, and go to CONFIRM; with CONFIRM_SAMPLES=1 it SHALL instead go directly to HOLDOFF and emit the onset.
REQ-020 CONFIRM: each valid above sample SHALL increment the count; when the count reaches CONFIRM_SAMPLES it SHALL emit the onset and go to HOLDOFF.
REQ-021 CONFIRM: a valid non-above sample SHALL discard the candidate and return to IDLE with no output change.
REQ-022 Emit onset: onset_valid SHALL be high for exactly one cycle, in the cycle after the confirming sample; onset_timestamp SHALL update to the candidate in that same cycle and hold until the next onset.
REQ-023 HOLDOFF: SHALL count valid samples, saturating at HOLDOFF_SAMPLES; it SHALL return to IDLE only on a valid below sample once the count equals HOLDOFF_SAMPLES (hysteresis); otherwise it stays in HOLDOFF.
REQ-024 enable=0 SHALL force IDLE on the next edge from any state with no pulse; an in-flight candidate is lost; onset_timestamp and onset_peak hold.
REQ-025 Samples arriving on consecutive cycles SHALL be handled at full rate; gaps in sample_valid SHALL not affect counts.

Reset
REQ-026 Asserting sresetn low at any time, including mid-CONFIRM or mid-HOLDOFF, SHALL asynchronously set state=IDLE and onset_valid=0, and clear onset_timestamp, onset_peak, busy, the timestamp counter, the confirm count and the holdoff count to 0.

Configuration
REQ-027 With ONSET_PEAK_EN defined, SHALL track the maximum valid sample from onset entry through CONFIRM and HOLDOFF, and present it on onset_peak updated on every max change; the value SHALL be reset to the entry sample at each new candidate.
REQ-028 Without ONSET_PEAK_EN, the onset_peak port and its tracking logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 SHALL have package onset_pkg holding the state enum (IDLE, CONFIRM, HOLDOFF) and the CONFIRM_SAMPLES/HOLDOFF_SAMPLES range-limit constants.
REQ-030 SHALL implement sub-module timestamp_counter (parameter TS_WIDTH; ports clk, sresetn, count) for the free-running counter.

Verification
REQ-031 Bench SHALL cover: thr_hi=100, thr_lo=50, CONFIRM=4; samples 10,120,130,140,150 back-to-back -> onset_valid pulse one cycle after 150, onset_timestamp = cycle of the 120 sample.
REQ-032 Bench SHALL cover: samples 120,130,90,140 -> no onset_valid, state returns to IDLE after 90, busy drops.
REQ-033 Bench SHALL cover: HOLDOFF=8; after an onset, 20 samples of 200 then 40 -> single onset only; IDLE only after the 40; a second burst then fires.
REQ-034 Bench SHALL cover: sresetn pulsed low mid-CONFIRM -> all outputs 0, no pulse; the sequence restarts cleanly.
REQ-035 Bench SHALL cover: TS_WIDTH=4 with an onset after counter wrap -> timestamp equals the wrapped value.
REQ-036 Bench SHALL cover, with ONSET_PEAK_EN defined: burst 120,300,250,130 -> onset_peak=300; enable dropped mid-HOLDOFF -> IDLE, onset_peak holds 300.

Source files
------------

// File: rtl/onset_pkg.sv
// Shared types and parameter limits for the onset detector.
package onset_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int CONFIRM_MIN   = 1;
    localparam int CONFIRM_MAX   = 255;
    localparam int HOLDOFF_MIN   = 1;
    localparam int HOLDOFF_MAX   = 65535;

    // Counter widths sized to hold the largest legal parameter value.
    localparam int CONFIRM_CNT_W = 8;
    localparam int HOLDOFF_CNT_W = 16;

endpackage

// File: rtl/timestamp_counter.sv
// Free-running wrap-around clock-cycle counter used to timestamp onsets.
module timestamp_counter #(
    parameter int TS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                sresetn,
    output logic [TS_WIDTH-1:0] count
);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples its inputs from before the clock edge.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            count <= '0;
        end else begin
            count <= count + TS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/onset_detector.sv
// Threshold onset detector with confirmation, hysteretic hold-off and timestamping.
// Define ONSET_PEAK_EN to add the onset_peak output and its max tracker.
module onset_detector
    import onset_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int TS_WIDTH        = 32,
    parameter int CONFIRM_SAMPLES = 4,
    parameter int HOLDOFF_SAMPLES = 1024
) (
    input  logic                  clk,
    input  logic                  sresetn,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] threshold_hi,
    input  logic [DATA_WIDTH-1:0] threshold_lo,
    input  logic                  enable,
    output logic                  onset_valid,
    output logic [TS_WIDTH-1:0]   onset_timestamp,
    output logic                  busy
`ifdef ONSET_PEAK_EN
    ,
    output logic [DATA_WIDTH-1:0] onset_peak
`endif
);

    if (CONFIRM_SAMPLES < CONFIRM_MIN || CONFIRM_SAMPLES > CONFIRM_MAX) begin : g_bad_confirm
        $error("CONFIRM_SAMPLES out of range");
    end
    if (HOLDOFF_SAMPLES < HOLDOFF_MIN || HOLDOFF_SAMPLES > HOLDOFF_MAX) begin : g_bad_holdoff
        $error("HOLDOFF_SAMPLES out of range");
    end

    localparam logic [CONFIRM_CNT_W-1:0] CONFIRM_TGT = CONFIRM_CNT_W'(CONFIRM_SAMPLES);
    localparam logic [HOLDOFF_CNT_W-1:0] HOLDOFF_TGT = HOLDOFF_CNT_W'(HOLDOFF_SAMPLES);

    state_t                     state, state_nxt;
    logic [TS_WIDTH-1:0]        ts_now;
    logic [TS_WIDTH-1:0]        cand_ts, cand_ts_nxt;
    logic [TS_WIDTH-1:0]        onset_ts_nxt;
    logic [CONFIRM_CNT_W-1:0]   conf_cnt, conf_cnt_nxt;
    logic [HOLDOFF_CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                       onset_valid_nxt;
    logic                       is_above, is_below;

    timestamp_counter #(.TS_WIDTH(TS_WIDTH)) u_ts (
        .clk     (clk),
        .sresetn (sresetn),
        .count   (ts_now)
    );

    assign is_above = sample_valid && (sample_in > threshold_hi);
    assign is_below = sample_valid && (sample_in < threshold_lo);
    assign busy     = (state != IDLE);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        cand_ts_nxt     = cand_ts;
        conf_cnt_nxt    = conf_cnt;
        hold_cnt_nxt    = hold_cnt;
        onset_valid_nxt = 1'b0;
        onset_ts_nxt    = onset_timestamp;

        if (!enable) begin
            state_nxt    = IDLE;
            conf_cnt_nxt = '0;
            hold_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_above) begin
                        cand_ts_nxt  = ts_now;
                        conf_cnt_nxt = CONFIRM_CNT_W'(1);
                        hold_cnt_nxt = '0;
                        if (CONFIRM_SAMPLES == 1) begin
                            state_nxt       = HOLDOFF;
                            onset_valid_nxt = 1'b1;
                            onset_ts_nxt    = ts_now;
                        end else begin
                            state_nxt = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (is_above) begin
                        conf_cnt_nxt = conf_cnt + CONFIRM_CNT_W'(1);
                        if (conf_cnt_nxt == CONFIRM_TGT) begin
                            state_nxt       = HOLDOFF;
                            hold_cnt_nxt    = '0;
                            onset_valid_nxt = 1'b1;
                            onset_ts_nxt    = cand_ts;
                        end
                    end else if (sample_valid) begin
                        state_nxt    = IDLE;
                        conf_cnt_nxt = '0;
                    end
                end
                HOLDOFF: begin
                    // Re-arm needs both the full hold-off and a drop below the low level.
                    if (sample_valid) begin
                        if (hold_cnt == HOLDOFF_TGT) begin
                            if (is_below) begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            hold_cnt_nxt = hold_cnt + HOLDOFF_CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state           <= IDLE;
            cand_ts         <= '0;
            conf_cnt        <= '0;
            hold_cnt        <= '0;
            onset_valid     <= 1'b0;
            onset_timestamp <= '0;
        end else begin
            state           <= state_nxt;
            cand_ts         <= cand_ts_nxt;
            conf_cnt        <= conf_cnt_nxt;
            hold_cnt        <= hold_cnt_nxt;
            onset_valid     <= onset_valid_nxt;
            onset_timestamp <= onset_ts_nxt;
        end
    end

`ifdef ONSET_PEAK_EN
    // Peak restarts at each new candidate and then only ever grows.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            onset_peak <= '0;
        end else if (enable && sample_valid) begin
            unique case (state)
                IDLE: begin
                    if (is_above) onset_peak <= sample_in;
                end
                CONFIRM, HOLDOFF: begin
                    if (sample_in > onset_peak) onset_peak <= sample_in;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_onset_detector.sv
// Self-checking bench for onset_detector: vector table plus timestamp scoreboard.
// Build with ONSET_PEAK_EN defined to also check onset_peak.
module tb_onset_detector;

    typedef struct {
        int s;      // sample value
        int v;      // sample_valid
        int e;      // enable
        int xv;     // expected onset_valid after the edge
        int xb;     // expected busy after the edge
        int f;      // this sample starts a candidate
        int p;      // this sample confirms an onset
    } vec_t;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] threshold_hi = 16'd100;
    logic [15:0] threshold_lo = 16'd50;
    logic        enable = 1'b1;
    logic        onset_valid;
    logic [31:0] onset_timestamp;
    logic        busy;
    logic [15:0] w_sample = '0;
    logic        w_valid = 1'b0;
    logic        w_onset_valid;
    logic [3:0]  w_onset_timestamp;
    logic        w_busy;
`ifdef ONSET_PEAK_EN
    logic [15:0] onset_peak;
    logic [15:0] w_onset_peak;
`endif

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] tb_cycle;
    logic [31:0] cand_cyc = '0;
    logic [31:0] exp_q[$];
    logic [3:0]  w_exp_q[$];
    vec_t        tbl[25];

    always #5 clk = ~clk;

    onset_detector #(
        .DATA_WIDTH(16), .TS_WIDTH(32), .CONFIRM_SAMPLES(4), .HOLDOFF_SAMPLES(8)
    ) dut (
        .clk(clk), .sresetn(sresetn), .sample_in(sample_in), .sample_valid(sample_valid),
        .threshold_hi(threshold_hi), .threshold_lo(threshold_lo), .enable(enable),
        .onset_valid(onset_valid), .onset_timestamp(onset_timestamp), .busy(busy)
`ifdef ONSET_PEAK_EN
        , .onset_peak(onset_peak)
`endif
    );

    onset_detector #(
        .DATA_WIDTH(16), .TS_WIDTH(4), .CONFIRM_SAMPLES(1), .HOLDOFF_SAMPLES(2)
    ) dut_w (
        .clk(clk), .sresetn(sresetn), .sample_in(w_sample), .sample_valid(w_valid),
        .threshold_hi(threshold_hi), .threshold_lo(threshold_lo), .enable(enable),
        .onset_valid(w_onset_valid), .onset_timestamp(w_onset_timestamp), .busy(w_busy)
`ifdef ONSET_PEAK_EN
        , .onset_peak(w_onset_peak)
`endif
    );

    // Reference cycle count: the value the DUT timestamp counter should hold.
    always @(posedge clk or negedge sresetn) begin
        if (!sresetn) tb_cycle <= '0;
        else          tb_cycle <= tb_cycle + 32'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboards: every onset pulse must match the oldest expected timestamp.
    always @(negedge clk) begin
        if (sresetn && onset_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL onset_unexpected: got ts %0d, expected no pulse", onset_timestamp);
            end else begin
                check("onset_timestamp", 64'(onset_timestamp), 64'(exp_q.pop_front()));
            end
        end
        if (sresetn && w_onset_valid) begin
            if (w_exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL w_onset_unexpected: got ts %0d, expected no pulse", w_onset_timestamp);
            end else begin
                check("w_onset_timestamp", 64'(w_onset_timestamp), 64'(w_exp_q.pop_front()));
            end
        end
    end

    // Called at a falling edge: drive one cycle of stimulus, check after the next edge.
    task automatic step(input int s, input int v, input int e, input int xv, input int xb,
                        input int f, input int p, input string tag);
        sample_in    = 16'(s);
        sample_valid = (v != 0);
        enable       = (e != 0);
        if (f != 0) cand_cyc = tb_cycle;
        if (p != 0) exp_q.push_back(cand_cyc);
        @(negedge clk);
        check({tag, " onset_valid"}, 64'(onset_valid), 64'(xv));
        check({tag, " busy"}, 64'(busy), 64'(xb));
    endtask

    task automatic w_step(input int s, input int xv, input int xb, input int p, input string tag);
        w_sample = 16'(s);
        w_valid  = 1'b1;
        if (p != 0) w_exp_q.push_back(tb_cycle[3:0]);
        @(negedge clk);
        check({tag, " w_onset_valid"}, 64'(w_onset_valid), 64'(xv));
        check({tag, " w_busy"}, 64'(w_busy), 64'(xb));
    endtask

    task automatic burst4(input string tag);
        step(120, 1, 1, 0, 1, 1, 0, tag);
        step(130, 1, 1, 0, 1, 0, 0, tag);
        step(140, 1, 1, 0, 1, 0, 0, tag);
        step(150, 1, 1, 1, 1, 0, 1, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl = '{
            '{ 10, 1, 1, 0, 0, 0, 0},   // below arm level, stays idle
            '{120, 1, 1, 0, 1, 1, 0},   // candidate start
            '{130, 1, 1, 0, 1, 0, 0},
            '{  5, 0, 1, 0, 1, 0, 0},   // gap: ignored
            '{140, 1, 1, 0, 1, 0, 0},
            '{150, 1, 1, 1, 1, 0, 1},   // fourth above sample confirms
            '{ 40, 1, 1, 0, 1, 0, 0},   // below too early: hold-off 1
            '{200, 0, 1, 0, 1, 0, 0},   // gap: not counted
            '{200, 1, 1, 0, 1, 0, 0},
            '{200, 1, 1, 0, 1, 0, 0},
            '{200, 1, 1, 0, 1, 0, 0},
            '{200, 1, 1, 0, 1, 0, 0},
            '{200, 1, 1, 0, 1, 0, 0},
            '{200, 1, 1, 0, 1, 0, 0},   // hold-off 7
            '{ 40, 1, 1, 0, 1, 0, 0},   // below at 7: reaches 8, still busy
            '{ 40, 1, 1, 0, 0, 0, 0},   // below at 8: back to idle
            '{120, 1, 1, 0, 1, 1, 0},
            '{130, 1, 1, 0, 1, 0, 0},
            '{ 90, 1, 1, 0, 0, 0, 0},   // not above: candidate dropped
            '{140, 1, 1, 0, 1, 1, 0},
            '{ 60, 1, 1, 0, 0, 0, 0},   // between levels also drops it
            '{100, 1, 1, 0, 0, 0, 0},   // equal to arm level is not above
            '{101, 1, 1, 0, 1, 1, 0},
            '{200, 1, 0, 0, 0, 0, 0},   // enable low forces idle
            '{200, 1, 1, 0, 1, 1, 0}    // left mid-confirm for the reset test
        };

        repeat (3) @(negedge clk);
        check("reset onset_valid", 64'(onset_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset onset_timestamp", 64'(onset_timestamp), 64'd0);
`ifdef ONSET_PEAK_EN
        check("reset onset_peak", 64'(onset_peak), 64'd0);
`endif
        sresetn = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].e, tbl[i].xv, tbl[i].xb, tbl[i].f, tbl[i].p,
                 $sformatf("row%0d", i));
        end

        // Asynchronous reset in the middle of a confirmation.
        step(130, 1, 1, 0, 1, 0, 0, "pre_reset");
        sresetn = 1'b0;
        #1;
        check("midreset onset_valid", 64'(onset_valid), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset onset_timestamp", 64'(onset_timestamp), 64'd0);
`ifdef ONSET_PEAK_EN
        check("midreset onset_peak", 64'(onset_peak), 64'd0);
`endif
        @(negedge clk);
        check("held_reset onset_valid", 64'(onset_valid), 64'd0);
        sresetn = 1'b1;

        // Clean restart, then a long above-level stretch must give one onset only.
        burst4("restart");
        for (int i = 0; i < 20; i++) step(200, 1, 1, 0, 1, 0, 0, $sformatf("hold%0d", i));
        step(40, 1, 1, 0, 0, 0, 0, "rearm");
        burst4("second");
        for (int i = 0; i < 8; i++) step(200, 1, 1, 0, 1, 0, 0, "hold2");
        step(40, 1, 1, 0, 0, 0, 0, "rearm2");

        // Peak tracking, then enable dropped during hold-off.
        step(120, 1, 1, 0, 1, 1, 0, "peak");
        step(300, 1, 1, 0, 1, 0, 0, "peak");
        step(250, 1, 1, 0, 1, 0, 0, "peak");
        step(130, 1, 1, 1, 1, 0, 1, "peak");
`ifdef ONSET_PEAK_EN
        check("onset_peak max", 64'(onset_peak), 64'd300);
`endif
        step(200, 1, 1, 0, 1, 0, 0, "peak_hold");
        step(200, 1, 0, 0, 0, 0, 0, "disable");
`ifdef ONSET_PEAK_EN
        check("onset_peak after disable", 64'(onset_peak), 64'd300);
`endif
        step(200, 1, 1, 0, 1, 1, 0, "new_cand");
`ifdef ONSET_PEAK_EN
        check("onset_peak new candidate", 64'(onset_peak), 64'd200);
`endif
        sample_valid = 1'b0;

        // Narrow-timestamp instance, long past its first wrap; single-sample confirm.
        w_step(120, 1, 1, 1, "w_first");
        w_step(30, 0, 1, 0, "w_hold");
        w_step(30, 0, 1, 0, "w_hold");
        w_step(30, 0, 0, 0, "w_rearm");
        w_step(100, 0, 0, 0, "w_equal");
        repeat (5) @(negedge clk);
        w_step(150, 1, 1, 1, "w_second");
        w_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("pending onsets", 64'(exp_q.size()), 64'd0);
        check("pending w onsets", 64'(w_exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
